durbin_coeff_bank: RTL and testbench
====================================

Name: durbin_coeff_bank

Overview:
Parametrised store for Levinson-Durbin predictor coefficients of every candidate order 1..MAX_ORDER. It accepts coefficients from the Durbin recursion as they are produced, then streams the set for the selected best order to the quantiser/residual stage over a valid/ready handshake. Successor to the fixed 12-order shift store: width and depth are generic, readout is non-destructive and replayable, and incomplete sets are checked and flagged.

Parameters:
MAX_ORDER, 12, highest LPC order stored (1..32)
COEFF_W, 12, signed coefficient width
ORDER_W, 5, width of order inputs; must satisfy 2^ORDER_W > MAX_ORDER

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iEnable  in  1  clock enable; when low, all state, outputs and the handshake hold
iClear  in  1  start of new block: zero all per-order fill counts
iLoad  in  1  write iCoeff into the set for order iM
iM  in  ORDER_W  order being loaded (1..MAX_ORDER)
iCoeff  in  COEFF_W  signed coefficient
iUnload  in  1  request to stream the set for order iBestM
iBestM  in  ORDER_W  selected order
iReady  in  1  downstream accepts oCoeff
oCoeff  out  COEFF_W  signed coefficient, registered
oValid  out  1  oCoeff valid
oLast  out  1  qualifies the final coefficient of the stream
oBusy  out  1  streaming in progress
oError  out  1  one-cycle pulse: rejected unload or load
oOverflow  out  1  sticky: load beyond capacity since the last iClear/reset

Behaviour:
- Storage: flat array of MAX_ORDER*(MAX_ORDER+1)/2 words, triangular layout, base(m) = m*(m-1)/2. One fill counter per order, range 0..m.
- Reset: all counters 0; FSM to IDLE; oCoeff=0, oValid=0, oLast=0, oBusy=0, oError=0, oOverflow=0. Array contents are not reset. Reset mid-stream aborts the stream with no oLast.
- All activity below requires iEnable=1. Priority: iReset > iClear > iLoad > iUnload.
- iClear: zero all counters and oOverflow; abort any stream (oValid=0, oBusy=0, go to IDLE). A same-cycle iLoad/iUnload is ignored.
- Load, accepted in IDLE only: if 1<=iM<=MAX_ORDER and count(iM)<iM, write array[base(iM)+count(iM)], then increment the count. If the count is full, set oOverflow and pulse oError with no write. If iM=0 or iM>MAX_ORDER, pulse oError only. iLoad while oBusy: dropped, oError pulse.
- iLoad and iUnload in the same IDLE cycle: the load is performed; the unload is ignored silently.
- Unload in IDLE: if iBestM is in range and count(iBestM)==iBestM, enter STREAM with idx=0. Otherwise pulse oError and stay in IDLE.
- FSM states:
  - IDLE: oBusy=0.
  - STREAM: oBusy=1. Coefficients go out in load order (first loaded, first out).
- Timing: unload accepted at edge N. At N+1, oValid=1 and oCoeff=array[base+0]. Each cycle with oValid&iReady advances idx, and the next word appears at the following edge, giving 1 word/cycle under continuous ready. oCoeff/oValid/oLast hold while iReady=0.
- oLast=1 with idx==iBestM-1. Acceptance of the last word returns the FSM to IDLE with oValid=0 on the next cycle.
- The selected order is latched at acceptance; iBestM changes mid-stream are ignored. iUnload while busy is ignored (no error).
- Readout is non-destructive: counts are unchanged, so the same order may be replayed or a different complete order unloaded until iClear.
- Order 1 stream is a single word with oValid and oLast together.

Decomposition:
- Shared package durbin_pkg: MAX_ORDER default, COEFF_W, ORDER_W, the triangular base-address constant function, and the FSM state encoding (IDLE, STREAM).
- One sub-module, coeff_tri_ram: single-write/single-read array with the address computed from (order, index) and a registered read. Counters, FSM and handshake stay in the top.

Test Plan:
- Load order 3 with 5, -7, 100; unload 3 with iReady=1 -> oValid for 3 cycles starting N+1, oCoeff = 5, -7, 100, oLast on 100, oBusy drops after.
- Load all orders 1..12 with value 16*m+k; unload 12 twice, then 1 -> identical replay of 12 words each time; order 1 yields a single word 17 with oLast=1.
- Unload 4 with iReady toggling 1,0,0,1,... -> oCoeff/oValid held during stalls; exactly 4 handshakes, no duplicates or skips.
- Load 2 words into order 3, then unload 3 -> oError pulse, no oValid. Load 4th word into full order 3 -> oOverflow=1, contents unchanged. Then iClear -> oOverflow=0, all counts 0.
- iLoad while oBusy -> oError pulse, stream unaffected. Same-cycle iLoad+iUnload in IDLE -> load written, no stream.
- iReset asserted mid-stream of order 8 -> next cycle oValid=0, oBusy=0, oLast=0. A subsequent unload 8 errors because counts were cleared. iEnable=0 for 3 cycles mid-stream -> outputs frozen, stream resumes intact.

Source files
------------

// File: rtl/durbin_coeff_bank_pkg.sv
// Shared types and constants for the Durbin coefficient bank.
// Coefficients are stored in a triangular layout: order m occupies
// m consecutive words starting at tri_base(m) = m*(m-1)/2.
package durbin_pkg;

    localparam int DEF_MAX_ORDER = 12;
    localparam int DEF_COEFF_W   = 12;
    localparam int DEF_ORDER_W   = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // First word of order m; tri_base(MAX_ORDER+1) is the total depth.
    function automatic int unsigned tri_base(input int unsigned m);
        if (m == 0)
            return 0;
        return (m * (m - 1)) / 2;
    endfunction

endpackage

// File: rtl/durbin_coeff_bank_if.sv
// Load / unload / stream bus of the coefficient bank.
// master: the Durbin recursion + downstream consumer side; slave: the bank.
interface durbin_coeff_bank_if
    import durbin_pkg::*;
#(
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int ORDER_W = DEF_ORDER_W
) ();
    logic               iLoad;
    logic [ORDER_W-1:0] iM;
    logic [COEFF_W-1:0] iCoeff;
    logic               iUnload;
    logic [ORDER_W-1:0] iBestM;
    logic               iReady;
    logic [COEFF_W-1:0] oCoeff;
    logic               oValid;
    logic               oLast;
    logic               oBusy;
    logic               oError;
    logic               oOverflow;

    modport slave (
        input  iLoad, iM, iCoeff, iUnload, iBestM, iReady,
        output oCoeff, oValid, oLast, oBusy, oError, oOverflow
    );

    modport master (
        output iLoad, iM, iCoeff, iUnload, iBestM, iReady,
        input  oCoeff, oValid, oLast, oBusy, oError, oOverflow
    );
endinterface

// File: rtl/durbin_coeff_bank_ram.sv
// Triangular coefficient array: one write port, one registered read port.
// Addresses are formed from (order, index); the caller guarantees range.
// The read register only updates on iRe so the presented word holds
// across downstream stalls.
module coeff_tri_ram
    import durbin_pkg::*;
#(
    parameter int MAX_ORDER = DEF_MAX_ORDER,
    parameter int COEFF_W   = DEF_COEFF_W,
    parameter int ORDER_W   = DEF_ORDER_W
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iWe,
    input  logic [ORDER_W-1:0] iWrM,
    input  logic [ORDER_W-1:0] iWrIdx,
    input  logic [COEFF_W-1:0] iWrData,
    input  logic               iRe,
    input  logic [ORDER_W-1:0] iRdM,
    input  logic [ORDER_W-1:0] iRdIdx,
    output logic [COEFF_W-1:0] oRdData
);
    localparam int DEPTH = int'(tri_base(MAX_ORDER + 1));
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [COEFF_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;

    assign wr_addr = AW'(tri_base(32'(iWrM)) + 32'(iWrIdx));
    assign rd_addr = AW'(tri_base(32'(iRdM)) + 32'(iRdIdx));

    // Array write; contents deliberately survive reset.
    always_ff @(posedge iClock) begin
        if (iWe)
            mem[wr_addr] <= iWrData;
    end

    // Registered read, cleared by reset so the output starts at zero.
    always_ff @(posedge iClock) begin
        if (iReset)
            oRdData <= '0;
        else if (iRe)
            oRdData <= mem[rd_addr];
    end
endmodule

// File: rtl/durbin_coeff_bank.sv
// Levinson-Durbin coefficient bank: collects coefficients for orders
// 1..MAX_ORDER and streams one complete order over valid/ready.
// Readout is non-destructive; fill counts persist until iClear/iReset.
module durbin_coeff_bank
    import durbin_pkg::*;
#(
    parameter int MAX_ORDER = DEF_MAX_ORDER,
    parameter int COEFF_W   = DEF_COEFF_W,
    parameter int ORDER_W   = DEF_ORDER_W
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iEnable,
    input  logic                 iClear,
    durbin_coeff_bank_if.slave   bus
);
    localparam int               NCNT = 2 ** ORDER_W;
    localparam logic [ORDER_W-1:0] MAXM = ORDER_W'(MAX_ORDER);

    state_t             state;
    logic [ORDER_W-1:0] cnt [NCNT];
    logic [ORDER_W-1:0] m_sel;
    logic [ORDER_W-1:0] idx;
    logic               valid_q, last_q, busy_q, err_q, ovf_q;

    logic               act;
    logic               ld_in_range, ld_room, ul_ok;
    logic [ORDER_W-1:0] cnt_m;
    logic               we, ul_go, adv, re;
    logic [ORDER_W-1:0] rd_m, rd_idx;
    logic [COEFF_W-1:0] rd_data;

    // Decode of the current request against the fill counts.
    always_comb begin
        act         = iEnable && !iReset && !iClear;
        cnt_m       = cnt[bus.iM];
        ld_in_range = (bus.iM != '0) && (bus.iM <= MAXM);
        ld_room     = cnt_m < bus.iM;
        ul_ok       = (bus.iBestM != '0) && (bus.iBestM <= MAXM) &&
                      (cnt[bus.iBestM] == bus.iBestM);
        we          = act && (state == IDLE) && bus.iLoad && ld_in_range && ld_room;
        ul_go       = act && (state == IDLE) && !bus.iLoad && bus.iUnload && ul_ok;
        adv         = act && (state == STREAM) && valid_q && bus.iReady;
        // Fetch word 0 on acceptance, then the next word on each handshake.
        re          = ul_go || (adv && !last_q);
        rd_m        = (state == IDLE) ? bus.iBestM : m_sel;
        rd_idx      = (state == IDLE) ? '0 : idx + 1'b1;
    end

    coeff_tri_ram #(
        .MAX_ORDER (MAX_ORDER),
        .COEFF_W   (COEFF_W),
        .ORDER_W   (ORDER_W)
    ) u_ram (
        .iClock  (iClock),
        .iReset  (iReset),
        .iWe     (we),
        .iWrM    (bus.iM),
        .iWrIdx  (cnt_m),
        .iWrData (bus.iCoeff),
        .iRe     (re),
        .iRdM    (rd_m),
        .iRdIdx  (rd_idx),
        .oRdData (rd_data)
    );

    // Fill counters, stream FSM and registered status outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= IDLE;
            m_sel   <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NCNT; i++)
                cnt[i] <= '0;
        end else if (iEnable) begin
            err_q <= 1'b0;
            if (iClear) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
                for (int i = 0; i < NCNT; i++)
                    cnt[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.iLoad) begin
                            // Load wins over a same-cycle unload.
                            if (!ld_in_range) begin
                                err_q <= 1'b1;
                            end else if (ld_room) begin
                                cnt[bus.iM] <= cnt_m + 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                                err_q <= 1'b1;
                            end
                        end else if (bus.iUnload) begin
                            if (ul_ok) begin
                                state   <= STREAM;
                                m_sel   <= bus.iBestM;
                                idx     <= '0;
                                valid_q <= 1'b1;
                                last_q  <= (bus.iBestM == ORDER_W'(1));
                                busy_q  <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        // Loads cannot be honoured mid-stream; unloads are ignored.
                        if (bus.iLoad)
                            err_q <= 1'b1;
                        if (adv) begin
                            if (last_q) begin
                                state   <= IDLE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                idx    <= idx + 1'b1;
                                last_q <= ((idx + ORDER_W'(2)) == m_sel);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oCoeff    = rd_data;
    assign bus.oValid    = valid_q;
    assign bus.oLast     = last_q;
    assign bus.oBusy     = busy_q;
    assign bus.oError    = err_q;
    assign bus.oOverflow = ovf_q;
endmodule

// File: tb/tb_durbin_coeff_bank.sv
// Scoreboard bench for durbin_coeff_bank. The reference model keeps one
// queue of loaded words per order; an accepted unload copies that queue
// into the expected-stream queue, which the monitor drains on handshakes.
module tb_durbin_coeff_bank;
    localparam int MAXO = 12;
    localparam int CW   = 12;
    localparam int OW   = 5;

    typedef struct { logic [CW-1:0] c; bit last; } exp_t;
    typedef struct { bit busy; bit err; bit ov; } st_t;

    logic iClock, iReset, iEnable, iClear;
    durbin_coeff_bank_if #(.COEFF_W(CW), .ORDER_W(OW)) bus ();

    durbin_coeff_bank #(.MAX_ORDER(MAXO), .COEFF_W(CW), .ORDER_W(OW)) dut (
        .iClock  (iClock),
        .iReset  (iReset),
        .iEnable (iEnable),
        .iClear  (iClear),
        .bus     (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    logic [CW-1:0] mdl [MAXO+1][$];
    exp_t exp_q[$];
    st_t  st_q[$];
    bit   m_busy, m_err, m_ov;
    int   m_rem;
    int   nchk = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m <= MAXO; m++) mdl[m].delete();
        m_busy = 0; m_rem = 0; m_ov = 0;
        exp_q.delete();
    endtask

    // Advance one clock edge and apply the reference model to it.
    task automatic step();
        int mm;
        @(posedge iClock);
        if (iReset) begin
            model_clear(); m_err = 0;
        end else if (iEnable) begin
            if (iClear) begin
                model_clear(); m_err = 0;
            end else begin
                m_err = 0;
                if (!m_busy) begin
                    if (bus.iLoad) begin
                        mm = int'(bus.iM);
                        if (mm >= 1 && mm <= MAXO) begin
                            if (mdl[mm].size() < mm) mdl[mm].push_back(bus.iCoeff);
                            else begin m_ov = 1; m_err = 1; end
                        end else m_err = 1;
                    end else if (bus.iUnload) begin
                        mm = int'(bus.iBestM);
                        if (mm >= 1 && mm <= MAXO && mdl[mm].size() == mm) begin
                            m_busy = 1; m_rem = mm;
                            for (int k = 0; k < mm; k++)
                                exp_q.push_back('{mdl[mm][k], (k == mm - 1)});
                        end else m_err = 1;
                    end
                end else begin
                    if (bus.iLoad) m_err = 1;
                    if (bus.iReady) begin
                        m_rem--;
                        if (m_rem == 0) m_busy = 0;
                    end
                end
            end
        end
        st_q.push_back('{m_busy, m_err, m_ov});
        #1;
    endtask

    // Monitor: per-cycle status from the model, stream words from the scoreboard.
    always @(negedge iClock) begin
        st_t  s;
        exp_t e;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("busy", bus.oBusy, s.busy);
            chk("valid", bus.oValid, s.busy);
            chk("error", bus.oError, s.err);
            chk("overflow", bus.oOverflow, s.ov);
            if (!s.busy) chk("last_idle", bus.oLast, 0);
        end
        if (bus.oValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL unexpected_valid: got oCoeff %0h with empty scoreboard at %0t", bus.oCoeff, $time);
            end else begin
                e = exp_q[0];
                chk("coeff", bus.oCoeff, e.c);
                chk("last", bus.oLast, e.last);
                if (bus.iReady && iEnable && !iReset && !iClear) void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle_in();
        bus.iLoad = 0; bus.iUnload = 0; bus.iM = '0; bus.iBestM = '0;
        bus.iCoeff = '0; iClear = 0; iReset = 0; iEnable = 1;
    endtask

    task automatic do_load(input int m, input int c);
        bus.iLoad = 1; bus.iM = OW'(m); bus.iCoeff = CW'(c);
        step();
        bus.iLoad = 0;
    endtask

    task automatic do_unload(input int m);
        bus.iUnload = 1; bus.iBestM = OW'(m);
        step();
        bus.iUnload = 0;
    endtask

    task automatic do_clear();
        iClear = 1; step(); iClear = 0;
    endtask

    // Run until the model stream ends; mode 0 = always ready, 1 = random ready.
    task automatic drain(input int mode);
        for (int i = 0; i < 300 && m_busy; i++) begin
            bus.iReady = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step();
        end
        if (m_busy) begin
            nchk++; nerr++;
            $display("FAIL drain_timeout: stream still busy, expected idle");
            m_busy = 0; exp_q.delete();
        end
        bus.iReady = 1;
    endtask

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idle_in(); bus.iReady = 1;
        m_busy = 0; m_err = 0; m_ov = 0; m_rem = 0;

        // Reset state
        iReset = 1; step(); step(); iReset = 0;
        chk("reset_coeff", bus.oCoeff, 0);

        // Order 3: 5, -7, 100
        do_load(3, 5); do_load(3, -7); do_load(3, 100);
        do_unload(3); drain(0);

        // All orders with 16*m+k, replay 12 twice, then order 1
        do_clear();
        for (int m = 1; m <= MAXO; m++)
            for (int k = 1; k <= m; k++) do_load(m, 16 * m + k);
        do_unload(12); drain(0);
        do_unload(12); drain(0);
        do_unload(1);  drain(0);

        // Stalled readout of order 4
        do_unload(4);
        for (int i = 0; i < 40 && m_busy; i++) begin
            bus.iReady = pat[i % 4]; step();
        end
        drain(0);

        // Incomplete set, overflow, clear
        do_clear();
        do_load(3, 11); do_load(3, 22);
        do_unload(3);
        do_load(3, 33); do_load(3, 44);
        do_unload(3); drain(0);
        do_clear();
        do_unload(3);

        // Load during stream; same-cycle load+unload
        for (int k = 0; k < 5; k++) do_load(5, $urandom_range(0, 4095));
        do_unload(5);
        do_load(2, 9);
        drain(1);
        bus.iLoad = 1; bus.iM = 2; bus.iCoeff = CW'(-3); bus.iUnload = 1; bus.iBestM = 5;
        step(); idle_in();
        do_load(2, 7); do_unload(2); drain(0);

        // Reset mid-stream of order 8
        for (int k = 0; k < 8; k++) do_load(8, $urandom_range(0, 4095));
        do_unload(8);
        bus.iReady = 1; step(); step(); step();
        iReset = 1; step(); iReset = 0;
        chk("midreset_coeff", bus.oCoeff, 0);
        do_unload(8);

        // Enable low mid-stream
        for (int k = 0; k < 8; k++) do_load(8, $urandom_range(0, 4095));
        do_unload(8);
        step(); step();
        iEnable = 0; step(); step(); step(); iEnable = 1;
        drain(1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            idle_in();
            r = $urandom_range(0, 99);
            bus.iReady = ($urandom_range(0, 3) != 0);
            if (r < 1)       iReset = 1;
            else if (r < 3)  iClear = 1;
            else if (r < 6)  iEnable = 0;
            else if (r < 55) begin
                bus.iLoad = 1; bus.iM = OW'($urandom_range(0, 9));
                bus.iCoeff = CW'($urandom);
                bus.iUnload = ($urandom_range(0, 7) == 0);
                bus.iBestM = OW'($urandom_range(0, 13));
            end else if (r < 75) begin
                bus.iUnload = 1; bus.iBestM = OW'($urandom_range(0, 13));
            end
            step();
        end
        idle_in();
        drain(1);
        step(); step();
        @(negedge iClock); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
